// File: rtl/mem_req_agent.sv
// Memory request agent: queues local read/write requests in a FIFO, issues them
// through an arbiter port, returns read data and flags prolonged starvation.
module mem_req_agent #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     req,
  input  logic                     gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     starve_clr,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_cnt_nxt;

  // Handshake and request line decode purely from registered occupancy
  assign in_ready = (count < CNT_W'(DEPTH));
  assign req      = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = req && gnt;
  assign head     = fifo_q[rd_ptr];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pop) begin
      mem_en    = 1'b1;
      mem_we    = head.we;
      mem_addr  = head.addr;
      mem_wdata = head.wdata;
    end
  end

  // Storage needs no reset; occupancy alone qualifies entries
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= entry_t'{we: in_we, addr: in_addr, wdata: in_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_valid <= 1'b0;
    else     rsp_valid <= pop && !head.we;
  end

  assign rsp_rdata = rsp_valid ? mem_rdata : '0;

  // Consecutive waiting cycles, saturating at the limit
  always_comb begin
    starve_cnt_nxt = '0;
    if (req && !gnt) begin
      if (starve_cnt == STV_W'(STARVE_LIMIT)) starve_cnt_nxt = starve_cnt;
      else                                    starve_cnt_nxt = starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || starve_clr) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (starve_cnt_nxt == STV_W'(STARVE_LIMIT)) starve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_agent.sv
// Bench for mem_req_agent: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_mem_req_agent;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LIMIT  = 64;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              req;
  logic              gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              starve_clr;
  logic              starve;
  logic [2:0]        count;

  mem_req_agent #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_addr(in_addr), .in_wdata(in_wdata), .req(req), .gnt(gnt), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .starve_clr(starve_clr),
    .starve(starve), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: ordered queue of accepted requests plus response/starve state
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  ent_t mq[$];
  bit   m_rsp;
  int   m_wait;
  bit   m_starve;

  task automatic model_check(string tag);
    bit   xfer;
    ent_t h;
    xfer = (mq.size() != 0) && gnt;
    h = '{we: 1'b0, addr: '0, wdata: '0};
    if (xfer) h = mq[0];
    chk({tag, ".count"},     64'(count),     64'(mq.size()));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
    chk({tag, ".req"},       64'(req),       64'(mq.size() != 0));
    chk({tag, ".mem_en"},    64'(mem_en),    64'(xfer));
    chk({tag, ".mem_we"},    64'(mem_we),    64'(h.we));
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'(h.addr));
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(h.wdata));
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rsp));
    chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), m_rsp ? 64'(mem_rdata) : 64'(0));
    chk({tag, ".starve"},    64'(starve),    64'(m_starve));
  endtask

  task automatic model_edge();
    bit do_push;
    bit xfer;
    if (rst) begin
      mq.delete();
      m_rsp    = 1'b0;
      m_wait   = 0;
      m_starve = 1'b0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      xfer    = (mq.size() != 0) && gnt;
      m_rsp   = xfer && !mq[0].we;
      if (starve_clr) begin
        m_wait   = 0;
        m_starve = 1'b0;
      end else begin
        if (mq.size() != 0 && !gnt) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        else                        m_wait = 0;
        if (m_wait == LIMIT) m_starve = 1'b1;
      end
      if (xfer) void'(mq.pop_front());
      if (do_push) mq.push_back('{we: in_we, addr: in_addr, wdata: in_wdata});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic iv, input logic we, input logic [15:0] a,
                       input logic [31:0] d, input logic g, input logic [31:0] rd,
                       input logic sc);
    rst = r; in_valid = iv; in_we = we; in_addr = a; in_wdata = d;
    gnt = g; mem_rdata = rd; starve_clr = sc;
    #1;
  endtask

  typedef struct {
    logic        iv, we;
    logic [15:0] a;
    logic [31:0] d;
    logic        g;
    logic [31:0] rd;
    logic [2:0]  e_count;
    logic        e_ready, e_req, e_en, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_rv;
    logic [31:0] e_rr;
  } vec_t;

  function automatic vec_t v(logic iv, logic we, logic [15:0] a, logic [31:0] d, logic g,
                             logic [31:0] rd, logic [2:0] c, logic rdy, logic rq, logic en,
                             logic ewe, logic [15:0] ea, logic [31:0] ed, logic rv,
                             logic [31:0] rr);
    vec_t t;
    t = '{iv, we, a, d, g, rd, c, rdy, rq, en, ewe, ea, ed, rv, rr};
    return t;
  endfunction

  vec_t tbl[16];

  initial begin
    // idle gnt, four queued writes, drain in order, then a single read with response
    tbl[0]  = v(0, 0, 16'h00, 32'h00, 1, 0,            0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[1]  = v(0, 0, 16'h00, 32'h00, 1, 0,            0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[2]  = v(1, 1, 16'h10, 32'hA0, 0, 0,            0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[3]  = v(1, 1, 16'h11, 32'hA1, 0, 0,            1, 1, 1, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[4]  = v(1, 1, 16'h12, 32'hA2, 0, 0,            2, 1, 1, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[5]  = v(1, 1, 16'h13, 32'hA3, 0, 0,            3, 1, 1, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[6]  = v(0, 0, 16'h00, 32'h00, 0, 0,            4, 0, 1, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[7]  = v(0, 0, 16'h00, 32'h00, 1, 0,            4, 0, 1, 1, 1, 16'h10, 32'hA0, 0, 0);
    tbl[8]  = v(0, 0, 16'h00, 32'h00, 1, 0,            3, 1, 1, 1, 1, 16'h11, 32'hA1, 0, 0);
    tbl[9]  = v(0, 0, 16'h00, 32'h00, 1, 0,            2, 1, 1, 1, 1, 16'h12, 32'hA2, 0, 0);
    tbl[10] = v(0, 0, 16'h00, 32'h00, 1, 0,            1, 1, 1, 1, 1, 16'h13, 32'hA3, 0, 0);
    tbl[11] = v(0, 0, 16'h00, 32'h00, 1, 0,            0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[12] = v(1, 0, 16'h20, 32'h00, 0, 0,            0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);
    tbl[13] = v(0, 0, 16'h00, 32'h00, 1, 0,            1, 1, 1, 1, 0, 16'h20, 32'h00, 0, 0);
    tbl[14] = v(0, 0, 16'h00, 32'h00, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 16'h00, 32'h00, 1, 32'hDEADBEEF);
    tbl[15] = v(0, 0, 16'h00, 32'h00, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 16'h00, 32'h00, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.count",    64'(count),    64'(0));
    chk("reset.in_ready", 64'(in_ready), 64'(1));
    chk("reset.req",      64'(req),      64'(0));
    chk("reset.mem_en",   64'(mem_en),   64'(0));
    chk("reset.rsp",      64'(rsp_valid), 64'(0));
    chk("reset.starve",   64'(starve),   64'(0));

    for (int i = 0; i < 16; i++) begin
      drive(0, tbl[i].iv, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].g, tbl[i].rd, 0);
      chk($sformatf("tbl%0d.count", i),     64'(count),     64'(tbl[i].e_count));
      chk($sformatf("tbl%0d.in_ready", i),  64'(in_ready),  64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d.req", i),       64'(req),       64'(tbl[i].e_req));
      chk($sformatf("tbl%0d.mem_en", i),    64'(mem_en),    64'(tbl[i].e_en));
      chk($sformatf("tbl%0d.mem_we", i),    64'(mem_we),    64'(tbl[i].e_we));
      chk($sformatf("tbl%0d.mem_addr", i),  64'(mem_addr),  64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wdata));
      chk($sformatf("tbl%0d.rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rv));
      chk($sformatf("tbl%0d.rsp_rdata", i), 64'(rsp_rdata), 64'(tbl[i].e_rr));
      model_check($sformatf("tblm%0d", i));
      tick();
    end

    // Full FIFO with grant and valid together: no push until the following cycle
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 16'h30 + 16'(i), 32'hB0 + 32'(i), 0, 0, 0);
      model_check("fill");
      tick();
    end
    drive(0, 1, 1, 16'h44, 32'hC4, 1, 0, 0);
    chk("full_pop.in_ready", 64'(in_ready), 64'(0));
    chk("full_pop.mem_addr", 64'(mem_addr), 64'(16'h30));
    model_check("full_pop");
    tick();
    drive(0, 1, 1, 16'h44, 32'hC4, 0, 0, 0);
    chk("after_full.in_ready", 64'(in_ready), 64'(1));
    model_check("after_full");
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      model_check("wrap_drain");
      tick();
    end

    // Starvation: one queued request held off for 65 cycles
    drive(0, 1, 1, 16'h55, 32'h55, 0, 0, 0);
    tick();
    for (int i = 1; i <= 66; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("starve_cyc%0d", i), 64'(starve), 64'(i >= 65));
      model_check("starve_wait");
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      chk("starve_sticky", 64'(starve), 64'(1));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("starve_clr", 64'(starve), 64'(0));
    model_check("starve_clr");

    // Reset while three requests queued and a read being granted
    drive(0, 1, 0, 16'h60, 32'h0, 0, 0, 0); tick();
    drive(0, 1, 1, 16'h61, 32'h1, 0, 0, 0); tick();
    drive(0, 1, 1, 16'h62, 32'h2, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst.count", 64'(count), 64'(3));
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h1234, 0);
    chk("post_rst.count",  64'(count),     64'(0));
    chk("post_rst.rsp",    64'(rsp_valid), 64'(0));
    chk("post_rst.req",    64'(req),       64'(0));
    chk("post_rst.mem_en", 64'(mem_en),    64'(0));
    model_check("post_rst");
    tick();

    // Randomized traffic: alternating well-granted and starved segments
    for (int seg = 0; seg < 12; seg++) begin
      int gpct;
      gpct = (seg % 3 == 1) ? 1 : 55;
      for (int c = 0; c < 200; c++) begin
        drive(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 60),
              1'($urandom),
              16'($urandom),
              $urandom,
              ($urandom_range(0, 99) < gpct),
              $urandom,
              ($urandom_range(0, 149) == 0));
        model_check("rand");
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
